// File: rtl/byte_data_memory_ctrl.sv
// rtl/byte_data_memory_ctrl.sv - byte-addressable data memory with row-split access handshake
module byte_data_memory_ctrl #(
   parameter int    BYTE_SIZE  = 4,
   parameter int    ADDR_WIDTH = 32,
   parameter int    DEPTH      = 128,
   parameter string INIT_FILE  = "codes/dataMemory.txt"
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   REQ,
   input  logic                   WE,
   input  logic [1:0]             SIZE,
   input  logic                   SIGNED,
   input  logic [ADDR_WIDTH-1:0]  ADDR,
   input  logic [BYTE_SIZE*8-1:0] WD,
   output logic [BYTE_SIZE*8-1:0] RD,
   output logic                   READY,
   output logic                   VALID,
   output logic                   ERR
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(BYTE_SIZE);

   typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

   state_t                        state_q;
   logic [7:0]                    mem_q [DEPTH];
   logic                          we_q;
   logic                          signed_q;
   logic [1:0]                    size_q;
   logic [AW-1:0]                 addr_q;
   logic [BYTE_SIZE*8-1:0]        wd_q;
   logic [BYTE_SIZE-1:0][7:0]     buf_q;
   logic [BYTE_SIZE*8-1:0]        rd_q;
   logic                          valid_q;
   logic                          err_q;

   logic                          c_we;
   logic                          c_signed;
   logic [1:0]                    c_size;
   logic [AW-1:0]                 c_addr;
   logic [BYTE_SIZE*8-1:0]        c_wd;
   int                            n_c;
   logic [ADDR_WIDTH:0]           end_c;
   logic                          err_c;
   logic                          cross_c;
   logic                          sign_c;
   logic [BYTE_SIZE-1:0][AW-1:0]  b_addr;
   logic [BYTE_SIZE-1:0]          first_c;
   logic [BYTE_SIZE-1:0]          wr_en;
   logic [BYTE_SIZE-1:0][7:0]     byte_c;
   logic [BYTE_SIZE-1:0][7:0]     ext_c;

   // Access context (live inputs in IDLE, latched fields afterwards), per-lane addressing and load assembly.
   always_comb begin
      if (state_q == IDLE) begin
         c_we     = WE;
         c_signed = SIGNED;
         c_size   = SIZE;
         c_addr   = ADDR[AW-1:0];
         c_wd     = WD;
      end else begin
         c_we     = we_q;
         c_signed = signed_q;
         c_size   = size_q;
         c_addr   = addr_q;
         c_wd     = wd_q;
      end
      n_c     = 1 << c_size;
      end_c   = {1'b0, ADDR} + (ADDR_WIDTH+1)'(n_c - 1);
      err_c   = (SIZE == 2'b11) || (n_c > BYTE_SIZE) || (end_c >= (ADDR_WIDTH+1)'(DEPTH));
      cross_c = (int'(c_addr[OW-1:0]) + n_c) > BYTE_SIZE;
      sign_c  = 1'b0;
      for (int k = 0; k < BYTE_SIZE; k++) begin
         b_addr[k]  = c_addr + AW'(k);
         first_c[k] = (int'(c_addr[OW-1:0]) + k) < BYTE_SIZE;
         // Second row cycle merges first-row bytes captured at acceptance with the new row.
         byte_c[k]  = (state_q == SPLIT && first_c[k]) ? buf_q[k] : mem_q[b_addr[k]];
         wr_en[k]   = rst_n && c_we && (k < n_c) &&
                      ((state_q == IDLE && REQ && !err_c && first_c[k]) ||
                       (state_q == SPLIT && !first_c[k]));
         if (k == n_c - 1) sign_c = byte_c[k][7];
      end
      for (int k = 0; k < BYTE_SIZE; k++) begin
         ext_c[k] = (k < n_c) ? byte_c[k] : {8{c_signed & sign_c}};
      end
   end

   // Byte-lane writes to storage; no reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      for (int k = 0; k < BYTE_SIZE; k++) begin
         if (wr_en[k]) mem_q[b_addr[k]] <= c_wd[k*8 +: 8];
      end
   end

   // Control FSM: accept in IDLE, optional second row cycle in SPLIT, completion pulse in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wd_q     <= '0;
         buf_q    <= '0;
         rd_q     <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (REQ) begin
                  we_q     <= WE;
                  signed_q <= SIGNED;
                  size_q   <= SIZE;
                  addr_q   <= ADDR[AW-1:0];
                  wd_q     <= WD;
                  buf_q    <= byte_c;
                  if (err_c) begin
                     state_q <= DONE;
                     valid_q <= 1'b1;
                     err_q   <= 1'b1;
                     rd_q    <= '0;
                  end else if (cross_c) begin
                     state_q <= SPLIT;
                  end else begin
                     state_q <= DONE;
                     valid_q <= 1'b1;
                     if (!WE) rd_q <= ext_c;
                  end
               end
            end
            SPLIT: begin
               state_q <= DONE;
               valid_q <= 1'b1;
               if (!we_q) rd_q <= ext_c;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign RD    = rd_q;
   assign READY = (state_q == IDLE);
   assign VALID = valid_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_byte_data_memory_ctrl.sv
// tb/tb_byte_data_memory_ctrl.sv - randomized self-checking bench for byte_data_memory_ctrl
module tb_byte_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        REQ;
   logic        WE;
   logic [1:0]  SIZE;
   logic        SIGNED;
   logic [31:0] ADDR;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        READY;
   logic        VALID;
   logic        ERR;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  model_mem [128];
   logic [31:0] rd_exp = 32'h0;

   byte_data_memory_ctrl #(
      .BYTE_SIZE (4),
      .ADDR_WIDTH(32),
      .DEPTH     (128),
      .INIT_FILE ("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .REQ   (REQ),
      .WE    (WE),
      .SIZE  (SIZE),
      .SIGNED(SIGNED),
      .ADDR  (ADDR),
      .WD    (WD),
      .RD    (RD),
      .READY (READY),
      .VALID (VALID),
      .ERR   (ERR)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One full transaction: model update, drive, junk inputs while busy, check latency and results.
   task automatic access(input string tag, input bit we, input bit [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
      int          n;
      int          lat;
      int          cnt;
      bit          e;
      bit          cr;
      logic [63:0] last;
      logic [31:0] val;
      n    = 1 << size;
      last = {32'h0, addr} + 64'(n) - 64'd1;
      e    = (size == 2'd3) || (n > 4) || (last >= 64'd128);
      cr   = !e && ((addr % 4) + n > 4);
      lat  = cr ? 2 : 1;
      if (e) begin
         rd_exp = 32'h0;
      end else if (we) begin
         for (int k = 0; k < n; k++) model_mem[addr + k] = wd[8*k +: 8];
      end else begin
         val = 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (k < n) val[8*k +: 8] = model_mem[addr + k];
            else       val[8*k +: 8] = (sgn && model_mem[addr + n - 1][7]) ? 8'hFF : 8'h00;
         end
         rd_exp = val;
      end
      check({tag, "_ready_pre"}, 32'(READY), 32'd1);
      WE = we; SIZE = size; SIGNED = sgn; ADDR = addr; WD = wd; REQ = 1'b1;
      @(posedge clk); #1;
      cnt = 1;
      REQ = 1'($urandom); WE = 1'($urandom); SIZE = 2'($urandom);
      SIGNED = 1'($urandom); ADDR = $urandom; WD = $urandom;
      while (!VALID && cnt < 5) begin
         check({tag, "_busy"}, 32'(READY), 32'd0);
         @(posedge clk); #1;
         cnt++;
      end
      REQ = 1'b0;
      check({tag, "_latency"}, 32'(cnt), 32'(lat));
      check({tag, "_ready_done"}, 32'(READY), 32'd0);
      check({tag, "_err"}, 32'(ERR), 32'(e));
      check({tag, "_rd"}, RD, rd_exp);
      @(posedge clk); #1;
      check({tag, "_valid_off"}, {31'h0, VALID, ERR}, 32'd0);
      check({tag, "_ready_back"}, 32'(READY), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; REQ = 1'b0; WE = 1'b0; SIZE = 2'd0; SIGNED = 1'b0; ADDR = 32'h0; WD = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {RD[31:3], READY, VALID, ERR}, 32'h4);
      check("reset_rd", RD, 32'h0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int r = 0; r < 32; r++) access("init", 1'b1, 2'd2, 1'b0, 32'(r * 4), $urandom);

      access("st_word", 1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
      access("ld_word", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
      check("ld_word_const", RD, 32'hDEADBEEF);

      access("st_byte80", 1'b1, 2'd0, 1'b0, 32'h10, 32'h00000080);
      access("ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
      check("ld_byte_s_const", RD, 32'hFFFFFF80);
      access("ld_byte_u", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
      check("ld_byte_u_const", RD, 32'h00000080);
      access("st_half", 1'b1, 2'd1, 1'b0, 32'h10, 32'h00008001);
      access("ld_half_s", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
      check("ld_half_s_const", RD, 32'hFFFF8001);

      access("st_split", 1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344);
      access("ld_split", 1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
      check("ld_split_const", RD, 32'h11223344);
      for (int k = 0; k < 4; k++) access("ld_split_b", 1'b0, 2'd0, 1'b0, 32'(14 + k), 32'h0);
      access("ld_half_split", 1'b0, 2'd1, 1'b1, 32'h0F, 32'h0);

      access("err_range", 1'b1, 2'd2, 1'b0, 32'h7E, 32'hCAFEF00D);
      access("err_chk7e", 1'b0, 2'd1, 1'b0, 32'h7E, 32'h0);
      access("err_size", 1'b1, 2'd3, 1'b0, 32'h00, 32'h12345678);
      access("err_half7f", 1'b0, 2'd1, 1'b0, 32'h7F, 32'h0);
      access("ok_word7c", 1'b0, 2'd2, 1'b1, 32'h7C, 32'h0);
      access("ok_byte7f", 1'b0, 2'd0, 1'b1, 32'h7F, 32'h0);
      access("err_huge", 1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0);

      // Reset during the second row cycle of a split store.
      WE = 1'b1; SIZE = 2'd2; SIGNED = 1'b0; ADDR = 32'h1E; WD = 32'hA1B2C3D4; REQ = 1'b1;
      @(posedge clk); #1;
      REQ = 1'b0;
      check("mid_split_busy", {30'h0, READY, VALID}, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_split_rst", {29'h0, READY, VALID, ERR}, 32'h4);
      @(posedge clk); #1;
      check("mid_split_novalid", 32'(VALID), 32'd0);
      #3 rst_n = 1'b1;
      model_mem[8'h1E] = 8'hD4;
      model_mem[8'h1F] = 8'hC3;
      rd_exp = 32'h0;
      @(posedge clk); #1;
      check("mid_split_rd", RD, 32'h0);
      access("mid_split_lo", 1'b0, 2'd2, 1'b0, 32'h1C, 32'h0);
      access("mid_split_hi", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

      // Asynchronous reset mid-cycle while RD holds load data.
      access("pre_async", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst", {29'h0, READY, VALID, ERR}, 32'h4);
      check("async_rst_rd", RD, 32'h0);
      rd_exp = 32'h0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         int          m;
         m = $urandom_range(0, 9);
         if (m < 8)       a = 32'($urandom_range(0, 127));
         else if (m == 8) a = 32'($urandom_range(120, 140));
         else             a = $urandom;
         access("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
